// File: rtl/benes_pkg.sv
// Shared constants, FSM state type and wiring helpers for the Benes
// permutation decoder. Port count is fixed at N = 2**LOGN.
package benes_pkg;

  localparam int LOGN   = 3;
  localparam int N      = 1 << LOGN;
  localparam int STAGES = 2 * LOGN - 1;
  localparam int SW     = N / 2;
  localparam int STG_W  = $clog2(STAGES);
  localparam int CFG_W  = STAGES * SW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Rotate the low k bits of p right by one; upper bits untouched.
  // New bit b takes old bit (b+1) mod k.
  function automatic logic [LOGN-1:0] rot_right_low(input logic [LOGN-1:0] p,
                                                    input int k);
    logic [LOGN-1:0] r;
    r = p;
    for (int b = 0; b < LOGN; b++) begin
      if (b < k) r[b] = p[(b + 1) % k];
    end
    return r;
  endfunction

  // Rotate the low k bits of p left by one; upper bits untouched.
  // New bit b takes old bit (b-1) mod k.
  function automatic logic [LOGN-1:0] rot_left_low(input logic [LOGN-1:0] p,
                                                   input int k);
    logic [LOGN-1:0] r;
    r = p;
    for (int b = 0; b < LOGN; b++) begin
      if (b < k) r[b] = p[(b + k - 1) % k];
    end
    return r;
  endfunction

endpackage

// File: rtl/benes_stage_step.sv
// One Benes stage applied to a single line position: the switch selected
// by the upper position bits optionally swaps the line with its partner,
// then the inter-stage wiring for that stage is applied. Purely
// combinational; the stage index selects which constant wiring is used.
module benes_stage_step
  import benes_pkg::*;
(
  input  logic [LOGN-1:0]  pos,
  input  logic [STG_W-1:0] stage,
  input  logic [CFG_W-1:0] cfg_r,
  output logic [LOGN-1:0]  next_pos
);

  logic [LOGN-1:0] switched;

  // Unroll over all stages so each wiring uses a constant rotate width.
  always_comb begin
    switched = pos;
    next_pos = pos;
    for (int s = 0; s < STAGES; s++) begin
      if (int'(stage) == s) begin
        switched = pos ^ {{(LOGN-1){1'b0}}, cfg_r[s*SW + int'(pos >> 1)]};
        if (s < LOGN - 1) begin
          next_pos = rot_right_low(switched, LOGN - s);
        end else if (s < STAGES - 1) begin
          next_pos = rot_left_low(switched, s - LOGN + 3);
        end else begin
          next_pos = switched;
        end
      end
    end
  end

endmodule

// File: rtl/benes_perm_decoder.sv
// Benes permutation decoder: given a full set of switch settings, traces
// every input through all stages (one stage per clock) and records the
// output port it reaches. Optional macro BENES_INV_EN adds perm_inv, the
// inverse table (output port -> input port), written alongside perm.
//
// Handshake: start is a request sampled only in IDLE; while busy or during
// the done pulse it is ignored. done is a one-cycle completion pulse and
// perm_valid qualifies perm (and perm_inv) from the cycle after done until
// the next accepted start or reset.
module benes_perm_decoder
  import benes_pkg::*;
(
  input  logic                clk,
  input  logic                areset,
  input  logic                start,
  input  logic [CFG_W-1:0]    sw_cfg,
  output logic                busy,
  output logic                done,
  output logic                perm_valid,
  output logic [N*LOGN-1:0]   perm
`ifdef BENES_INV_EN
  ,
  output logic [N*LOGN-1:0]   perm_inv
`endif
);

  state_t           state_q, state_d;
  logic [CFG_W-1:0] cfg_r;
  logic [LOGN-1:0]  in_idx;
  logic [STG_W-1:0] stage;
  logic [LOGN-1:0]  pos;
  logic [LOGN-1:0]  next_pos;
  logic             last_stage;
  logic             last_input;

  assign last_stage = (stage == STG_W'(STAGES - 1));
  assign last_input = (in_idx == LOGN'(N - 1));

  assign busy = (state_q == TRACE);
  assign done = (state_q == DONE);

  benes_stage_step u_step (
    .pos      (pos),
    .stage    (stage),
    .cfg_r    (cfg_r),
    .next_pos (next_pos)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = TRACE;
      TRACE:   if (last_stage && last_input) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Trace datapath: counters, captured config and result table writes.
  always_ff @(posedge clk) begin
    if (areset) begin
      cfg_r      <= '0;
      in_idx     <= '0;
      stage      <= '0;
      pos        <= '0;
      perm       <= '0;
      perm_valid <= 1'b0;
`ifdef BENES_INV_EN
      perm_inv   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_r      <= sw_cfg;
            perm_valid <= 1'b0;
            in_idx     <= '0;
            stage      <= '0;
            pos        <= '0;
          end
        end
        TRACE: begin
          if (last_stage) begin
            perm[int'(in_idx)*LOGN +: LOGN] <= next_pos;
`ifdef BENES_INV_EN
            perm_inv[int'(next_pos)*LOGN +: LOGN] <= in_idx;
`endif
            if (!last_input) begin
              in_idx <= in_idx + LOGN'(1);
              stage  <= '0;
              pos    <= in_idx + LOGN'(1);
            end
          end else begin
            stage <= stage + STG_W'(1);
            pos   <= next_pos;
          end
        end
        DONE: begin
          perm_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_benes_perm_decoder.sv
// Testbench for benes_perm_decoder: directed topology cases, random
// configurations against a behavioural trace model, protocol and reset.
module tb_benes_perm_decoder;
  import benes_pkg::*;

  logic              clk;
  logic              areset;
  logic              start;
  logic [CFG_W-1:0]  sw_cfg;
  logic              busy;
  logic              done;
  logic              perm_valid;
  logic [N*LOGN-1:0] perm;
`ifdef BENES_INV_EN
  logic [N*LOGN-1:0] perm_inv;
`endif

  int n_checks;
  int n_fail;

  benes_perm_decoder dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .sw_cfg     (sw_cfg),
    .busy       (busy),
    .done       (done),
    .perm_valid (perm_valid),
    .perm       (perm)
`ifdef BENES_INV_EN
    ,
    .perm_inv   (perm_inv)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: follow each input through the network using integer
  // arithmetic on the line number.
  function automatic logic [N*LOGN-1:0] model_perm(input logic [CFG_W-1:0] c);
    logic [N*LOGN-1:0] m;
    int p, k, lo, hi, md;
    m = '0;
    for (int i = 0; i < N; i++) begin
      p = i;
      for (int s = 0; s < STAGES; s++) begin
        if (c[s*SW + p/2]) p = (p % 2 == 0) ? p + 1 : p - 1;
        k = 0;
        if (s < LOGN - 1) k = LOGN - s;
        else if (s < STAGES - 1) k = s - LOGN + 3;
        if (k > 0) begin
          md = 1 << k;
          lo = p % md;
          hi = p - lo;
          if (s < LOGN - 1) lo = (lo / 2) + ((lo % 2) * (md / 2));
          else              lo = ((lo * 2) % md) + (lo / (md / 2));
          p = hi + lo;
        end
      end
      m[i*LOGN +: LOGN] = LOGN'(p);
    end
    return m;
  endfunction

  function automatic logic [N*LOGN-1:0] model_inv(input logic [N*LOGN-1:0] f);
    logic [N*LOGN-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[int'(f[i*LOGN +: LOGN])*LOGN +: LOGN] = LOGN'(i);
    return v;
  endfunction

  function automatic logic [N*LOGN-1:0] pack8(input int a [N]);
    logic [N*LOGN-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*LOGN +: LOGN] = LOGN'(a[i]);
    return v;
  endfunction

  // Driver: issue one start and observe a fixed 60-cycle window.
  // Window sample c lies in the cycle after edge T+c-1 (T = accept edge).
  task automatic run_decode(input logic [CFG_W-1:0] cfg, input bit reassert,
                            input bit toggle, output int lat, output int busy_cnt,
                            output int done_cnt, output logic pv_early);
    @(negedge clk);
    sw_cfg = cfg;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_cnt = 0; done_cnt = 0; pv_early = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) pv_early = perm_valid;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = c - 1;
      end
      start = (reassert && (c == 5 || c == 39)) ? 1'b1 : 1'b0;
      if (toggle && c == 10) sw_cfg = ~cfg;
      if (toggle && c == 20) sw_cfg = CFG_W'($urandom());
    end
  endtask

  task automatic check_result(input string name, input logic [N*LOGN-1:0] exp_p,
                              input int lat, input int busy_cnt, input int done_cnt,
                              input logic pv_early);
    // Each comparison below is inline; the task only groups a decode's checks.
    n_checks++;
    if (lat !== 40) begin n_fail++; $display("FAIL %s latency: got %0d expected 40", name, lat); end
    n_checks++;
    if (busy_cnt !== 40) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected 40", name, busy_cnt); end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt); end
    n_checks++;
    if (pv_early !== 1'b0) begin n_fail++; $display("FAIL %s perm_valid_cleared: got %b expected 0", name, pv_early); end
    n_checks++;
    if (perm_valid !== 1'b1) begin n_fail++; $display("FAIL %s perm_valid: got %b expected 1", name, perm_valid); end
    n_checks++;
    if (perm !== exp_p) begin n_fail++; $display("FAIL %s perm: got %h expected %h", name, perm, exp_p); end
`ifdef BENES_INV_EN
    n_checks++;
    if (perm_inv !== model_inv(exp_p)) begin
      n_fail++; $display("FAIL %s perm_inv: got %h expected %h", name, perm_inv, model_inv(exp_p));
    end
`endif
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; sw_cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || perm_valid !== 1'b0 || perm !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b pv=%b perm=%h expected all 0",
               busy, done, perm_valid, perm);
    end
    areset = 1'b0;
  endtask

  task automatic test_identity();
    int lat, bc, dc; logic pv;
    int a [N] = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_decode('0, 1'b0, 1'b0, lat, bc, dc, pv);
    check_result("identity", pack8(a), lat, bc, dc, pv);
  endtask

  task automatic test_last_swap();
    int lat, bc, dc; logic pv;
    int a [N] = '{1, 0, 2, 3, 4, 5, 6, 7};
    logic [CFG_W-1:0] c;
    c = '0; c[4*SW + 0] = 1'b1;
    run_decode(c, 1'b0, 1'b0, lat, bc, dc, pv);
    check_result("last_swap", pack8(a), lat, bc, dc, pv);
  endtask

  task automatic test_mid_swap();
    int lat, bc, dc; logic pv;
    int a [N] = '{4, 1, 2, 3, 0, 5, 6, 7};
    logic [CFG_W-1:0] c;
    c = '0; c[2*SW + 0] = 1'b1;
    run_decode(c, 1'b0, 1'b0, lat, bc, dc, pv);
    check_result("mid_swap", pack8(a), lat, bc, dc, pv);
  endtask

  task automatic test_all_ones();
    int lat, bc, dc; logic pv;
    bit seen [N];
    run_decode('1, 1'b0, 1'b0, lat, bc, dc, pv);
    check_result("all_ones", model_perm('1), lat, bc, dc, pv);
    n_checks++;
    if (perm[0 +: LOGN] !== LOGN'(4)) begin
      n_fail++; $display("FAIL all_ones_perm0: got %0d expected 4", perm[0 +: LOGN]);
    end
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int i = 0; i < N; i++) seen[int'(perm[i*LOGN +: LOGN])] = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (seen[i] !== 1'b1) begin n_fail++; $display("FAIL all_ones_bijection: output %0d got unreached expected reached", i); end
    end
  endtask

  task automatic test_random();
    int lat, bc, dc; logic pv;
    logic [CFG_W-1:0] c;
    for (int t = 0; t < 6; t++) begin
      c = CFG_W'($urandom());
      run_decode(c, 1'b0, 1'b0, lat, bc, dc, pv);
      check_result("random", model_perm(c), lat, bc, dc, pv);
    end
  endtask

  task automatic test_protocol();
    int lat, bc, dc; logic pv;
    logic [CFG_W-1:0] c;
    c = CFG_W'($urandom());
    run_decode(c, 1'b1, 1'b0, lat, bc, dc, pv);
    check_result("start_reassert", model_perm(c), lat, bc, dc, pv);
    c = CFG_W'($urandom());
    run_decode(c, 1'b0, 1'b1, lat, bc, dc, pv);
    check_result("cfg_toggle", model_perm(c), lat, bc, dc, pv);
  endtask

  task automatic test_abort_reset();
    int lat, bc, dc; logic pv;
    int dcnt;
    logic [CFG_W-1:0] c;
    @(negedge clk);
    sw_cfg = CFG_W'($urandom());
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || perm_valid !== 1'b0 || perm !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b pv=%b done=%b perm=%h expected all 0",
               busy, perm_valid, done, perm);
    end
    dcnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dcnt); end
    c = CFG_W'($urandom());
    run_decode(c, 1'b0, 1'b0, lat, bc, dc, pv);
    check_result("after_abort", model_perm(c), lat, bc, dc, pv);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_identity();
    test_last_swap();
    test_mid_swap();
    test_all_ones();
    test_random();
    test_protocol();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/benes_perm_decoder.md
Name: benes_perm_decoder

Overview:
- Inverse of the switch-colouring encoder. Takes a complete set of Benes switch settings and reconstructs the permutation they realise (input port → output port).
- Sequential: traces each input through every stage, one stage per clock.
- Uses: closed-loop check of colouring results, and the source of the routing table for downstream consumers.

Parameters:
- LOGN, 3, log2 of port count; N = 2**LOGN ports; STAGES = 2*LOGN-1; SW = N/2 switches per stage (derived localparams, not overridable).

Ports:
- clk  input  1  clock
- areset  input  1  reset, synchronous, active-high (sampled on posedge clk only)
- start  input  1  request decode; accepted only in IDLE
- sw_cfg  input  STAGES*SW  switch controls; bit s*SW+j = stage s, switch j; 1 = cross, 0 = straight
- busy  output  1  decode in progress
- done  output  1  one-cycle pulse, result complete
- perm_valid  output  1  perm holds a complete result
- perm  output  N*LOGN  perm[i*LOGN +: LOGN] = output port reached by input i

Behaviour:
- Reset (areset=1 at a posedge): state=IDLE; busy=0, done=0, perm_valid=0, perm=0; internal counters=0. Reset mid-decode aborts immediately, and no done is produced.
- Topology, line position p in [0,N):
  - Stage s: p ← p ^ sw_cfg[s*SW + (p>>1)].
  - Wiring after stage s, for s < LOGN-1: rotate right the low (LOGN-s) bits of p.
  - Wiring after stage s, for LOGN-1 ≤ s < STAGES-1: rotate left the low (s-LOGN+3) bits of p.
  - No wiring after the last stage.
- FSM states: IDLE, TRACE, DONE.
  - IDLE:
    - start=1 → capture sw_cfg into cfg_r, perm_valid←0, in_idx←0, stage←0, pos←0, busy←1 → TRACE.
    - start=0 → stay in IDLE.
  - TRACE:
    - Each cycle applies stage `stage` (switch plus following wiring) to pos.
    - When stage = STAGES-1: write the switched pos into perm slot in_idx, then:
      - if in_idx = N-1 → DONE;
      - else in_idx+1, stage←0, pos←in_idx+1.
  - DONE: done=1 and perm_valid←1 for exactly one cycle, busy←0 → IDLE.
- Latency: start accepted at edge T → done high in the cycle after edge T+N*STAGES (N=8: 40 TRACE cycles). busy is high in exactly those 40 cycles.
- Other timing rules:
  - start while busy or in DONE is ignored (no queueing).
  - sw_cfg changes during a decode have no effect, because cfg_r is used throughout.
  - perm slots not yet written in the current decode keep their old values; consumers qualify perm with perm_valid.
  - perm and perm_valid hold after DONE until the next accepted start or reset.
- Widths: pos, in_idx are LOGN bits. stage is ceil(log2(STAGES)) bits and never exceeds STAGES-1. in_idx increments never wrap because the DONE transition preempts them.

Optional Feature:
- BENES_INV_EN defined:
  - Adds output perm_inv (N*LOGN). On each slot write, perm_inv[pos_final*LOGN +: LOGN] ← in_idx.
  - perm_inv resets to 0 and is qualified by the same perm_valid.
  - A duplicate final position in one decode is impossible by construction.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package benes_pkg:
  - LOGN default, derived N/STAGES/SW constants, state enum (IDLE/TRACE/DONE).
  - Functions rot_right_low(p,k) and rot_left_low(p,k).
- Sub-module benes_stage_step (combinational): inputs pos, stage, cfg_r; output next pos. Instantiated once; the FSM, counters and table writes stay in the top.

Test Plan:
- Identity: sw_cfg=0, start pulse → done exactly 40 cycles after the accepting edge; perm = 0,1,2,3,4,5,6,7; perm_valid=1.
- Last-stage swap: only stage 4 switch 0 set → perm = 1,0,2,3,4,5,6,7.
- Middle-stage swap: only stage 2 switch 0 set → perm = 4,1,2,3,0,5,6,7; with BENES_INV_EN, perm_inv identical.
- All ones: sw_cfg all 1 → perm[0]=4. Result is a bijection, checked against a software model.
- Protocol:
  - start re-asserted at cycles 5 and 39 of busy → ignored, a single done.
  - sw_cfg toggled mid-decode → result equals the captured value.
- Reset: areset at busy cycle 20 → next cycle busy=0, perm_valid=0, perm=0, no done. A following start decodes correctly.
